// File: rtl/vga_fade_out_stage.sv
// vga_fade_out_stage: VGA output stage between the sync/graphics generators and the pins.
//   Registers graphics RGB on the pixel tick. Delays hsync/vsync/video_on by PIPE_DEPTH ticks.
//   Blanks colour outside the active area. Applies a frame-synchronous brightness fade.
// Ports:
//   clk, reset (async, active-low), p_tick (pixel enable)
//   hsync_in, vsync_in, video_on_in, rgb_in {R,G,B} : from sync / graphics generators
//   fade_req : one-clk pulse that starts or reverses a fade
//   hsync, vsync : delayed syncs
//   red, grn, blu : blanked, scaled colour
//   fade_busy : high while fading
//   black : high while held dark
// Optional feature: define TEST_PATTERN_EN to add the tp_en / pix_x colour-bar source.
module vga_fade_out_stage #(
    parameter int unsigned CH_BITS         = 4,
    parameter int unsigned PIPE_DEPTH      = 1,
    parameter int unsigned FADE_LOG2       = 4,
    parameter int unsigned FRAMES_PER_STEP = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p_tick,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 video_on_in,
    input  logic [3*CH_BITS-1:0] rgb_in,
`ifdef TEST_PATTERN_EN
    input  logic                 tp_en,
    input  logic [9:0]           pix_x,
`endif
    input  logic                 fade_req,
    output logic                 hsync,
    output logic                 vsync,
    output logic [CH_BITS-1:0]   red,
    output logic [CH_BITS-1:0]   grn,
    output logic [CH_BITS-1:0]   blu,
    output logic                 fade_busy,
    output logic                 black
);

    localparam int unsigned LVL_W  = FADE_LOG2 + 1;
    localparam int unsigned PROD_W = CH_BITS + FADE_LOG2 + 1;
    localparam int unsigned STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(2 ** FADE_LOG2);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {StBright, StFadeOut, StDark, StFadeIn} state_e;

    state_e                state_q, state_d;
    logic [LVL_W-1:0]      lvl_q, lvl_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic                  vsync_prev_q;
    logic                  fade_busy_q, fade_busy_d;
    logic                  black_q, black_d;
    logic [3*CH_BITS-1:0]  rgb_q, rgb_d;
    logic [3*CH_BITS-1:0]  src_rgb;
    logic [PROD_W-1:0]     prod;
    logic                  frame_evt;
    logic                  hs_dly, vs_dly, von_dly;

    // Colour source
`ifdef TEST_PATTERN_EN
    // Colour bars: bar = pix_x[9:7]; bit 2/1/0 lights R/G/B fully.
    always_comb begin
        src_rgb = rgb_in;
        if (tp_en) begin
            src_rgb = {{CH_BITS{pix_x[9]}}, {CH_BITS{pix_x[8]}}, {CH_BITS{pix_x[7]}}};
        end
    end
`else
    assign src_rgb = rgb_in;
`endif

    // Colour path: per-channel (c * lvl) >> FADE_LOG2, captured on p_tick
    always_comb begin
        rgb_d = rgb_q;
        prod  = '0;
        if (p_tick) begin
            for (int k = 0; k < 3; k++) begin
                prod = PROD_W'(src_rgb[k*CH_BITS +: CH_BITS]) * PROD_W'(lvl_q);
                rgb_d[k*CH_BITS +: CH_BITS] = prod[FADE_LOG2 +: CH_BITS];
            end
        end
    end

    // Sync path
    if (PIPE_DEPTH == 0) begin : g_no_pipe
        assign hs_dly  = hsync_in;
        assign vs_dly  = vsync_in;
        assign von_dly = video_on_in;
    end else begin : g_pipe
        logic [2:0] pipe_q [PIPE_DEPTH];
        logic [2:0] pipe_d [PIPE_DEPTH];

        always_comb begin
            pipe_d = pipe_q;
            if (p_tick) begin
                pipe_d[0] = {hsync_in, vsync_in, video_on_in};
                for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign {hs_dly, vs_dly, von_dly} = pipe_q[PIPE_DEPTH-1];
    end

    // Frame event: rising edge of vsync_in seen on clk
    assign frame_evt = vsync_in & ~vsync_prev_q;

    // Fade FSM: a fade_req transition always beats a same-cycle frame event
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        step_d  = step_q;
        unique case (state_q)
            StBright: begin
                if (fade_req) begin
                    state_d = StFadeOut;
                    step_d  = '0;
                end
            end
            StDark: begin
                if (fade_req) begin
                    state_d = StFadeIn;
                    step_d  = '0;
                end
            end
            StFadeOut: begin
                if (fade_req) begin
                    state_d = StFadeIn;
                    step_d  = '0;
                end else if (frame_evt) begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        // Clamp at 0 so a reversal that started at 0 still terminates
                        if (lvl_q <= LVL_W'(1)) begin
                            lvl_d   = '0;
                            state_d = StDark;
                        end else begin
                            lvl_d = lvl_q - LVL_W'(1);
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            StFadeIn: begin
                if (fade_req) begin
                    state_d = StFadeOut;
                    step_d  = '0;
                end else if (frame_evt) begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (lvl_q >= LVL_FULL - LVL_W'(1)) begin
                            lvl_d   = LVL_FULL;
                            state_d = StBright;
                        end else begin
                            lvl_d = lvl_q + LVL_W'(1);
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            default: begin
                state_d = StBright;
                lvl_d   = LVL_FULL;
                step_d  = '0;
            end
        endcase
        // Status flags track the state register one-for-one
        fade_busy_d = (state_d == StFadeOut) || (state_d == StFadeIn);
        black_d     = (state_d == StDark);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StBright;
            lvl_q        <= LVL_FULL;
            step_q       <= '0;
            vsync_prev_q <= 1'b0;
            fade_busy_q  <= 1'b0;
            black_q      <= 1'b0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            lvl_q        <= lvl_d;
            step_q       <= step_d;
            vsync_prev_q <= vsync_in;
            fade_busy_q  <= fade_busy_d;
            black_q      <= black_d;
            rgb_q        <= rgb_d;
        end
    end

    // Outputs
    assign hsync     = hs_dly;
    assign vsync     = vs_dly;
    assign red       = von_dly ? rgb_q[2*CH_BITS +: CH_BITS] : '0;
    assign grn       = von_dly ? rgb_q[CH_BITS +: CH_BITS]   : '0;
    assign blu       = von_dly ? rgb_q[0 +: CH_BITS]         : '0;
    assign fade_busy = fade_busy_q;
    assign black     = black_q;

endmodule

// File: tb/tb_vga_fade_out_stage.sv
// Directed testbench for vga_fade_out_stage (default parameters).
module tb_vga_fade_out_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        hsync_in;
    logic        vsync_in;
    logic        video_on_in;
    logic [11:0] rgb_in;
`ifdef TEST_PATTERN_EN
    logic        tp_en;
    logic [9:0]  pix_x;
`endif
    logic        fade_req;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  grn;
    logic [3:0]  blu;
    logic        fade_busy;
    logic        black;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_fade_out_stage #(
        .CH_BITS        (4),
        .PIPE_DEPTH     (1),
        .FADE_LOG2      (4),
        .FRAMES_PER_STEP(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .video_on_in(video_on_in),
        .rgb_in     (rgb_in),
`ifdef TEST_PATTERN_EN
        .tp_en      (tp_en),
        .pix_x      (pix_x),
`endif
        .fade_req   (fade_req),
        .hsync      (hsync),
        .vsync      (vsync),
        .red        (red),
        .grn        (grn),
        .blu        (blu),
        .fade_busy  (fade_busy),
        .black      (black)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame event: vsync_in high for one clk, then low for one clk
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_in = 1'b1;
            tick();
            vsync_in = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_req();
        fade_req = 1'b1;
        tick();
        fade_req = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        p_tick      = 1'b1;
        hsync_in    = 1'b1;
        vsync_in    = 1'b0;
        video_on_in = 1'b1;
        rgb_in      = 12'hFFF;
        fade_req    = 1'b0;
`ifdef TEST_PATTERN_EN
        tp_en       = 1'b0;
        pix_x       = 10'd0;
`endif
        tick();
        tick();

        // 1. Reset state
        check("rst_red", 32'(red), 32'h0);
        check("rst_grn", 32'(grn), 32'h0);
        check("rst_blu", 32'(blu), 32'h0);
        check("rst_hsync", 32'(hsync), 32'h0);
        check("rst_vsync", 32'(vsync), 32'h0);
        check("rst_busy", 32'(fade_busy), 32'h0);
        check("rst_black", 32'(black), 32'h0);

        reset  = 1'b1;
        rgb_in = 12'hF80;
        tick();
        check("pass_red", 32'(red), 32'hF);
        check("pass_grn", 32'(grn), 32'h8);
        check("pass_blu", 32'(blu), 32'h0);
        check("pass_hsync_hi", 32'(hsync), 32'h1);
        hsync_in = 1'b0;
        tick();
        check("pass_hsync_lo", 32'(hsync), 32'h0);

        // Pipeline holds without p_tick
        p_tick   = 1'b0;
        rgb_in   = 12'h000;
        hsync_in = 1'b1;
        tick();
        tick();
        check("hold_red", 32'(red), 32'hF);
        check("hold_hsync", 32'(hsync), 32'h0);
        p_tick = 1'b1;

        // 2. Blanking for one delayed pixel
        video_on_in = 1'b0;
        rgb_in      = 12'hFFF;
        tick();
        check("blank_red", 32'(red), 32'h0);
        check("blank_grn", 32'(grn), 32'h0);
        check("blank_blu", 32'(blu), 32'h0);
        video_on_in = 1'b1;
        rgb_in      = 12'hF80;
        tick();
        check("unblank_red", 32'(red), 32'hF);
        check("unblank_grn", 32'(grn), 32'h8);

        // 3. Full fade out
        pulse_req();
        check("fo_busy", 32'(fade_busy), 32'h1);
        check("fo_black", 32'(black), 32'h0);
        frames(1);
        check("fo_1ev_red", 32'(red), 32'hF);
        frames(1);
        check("fo_2ev_red", 32'(red), 32'hE);
        check("fo_2ev_grn", 32'(grn), 32'h7);
        frames(29);
        check("fo_31ev_black", 32'(black), 32'h0);
        check("fo_31ev_busy", 32'(fade_busy), 32'h1);
        frames(1);
        check("fo_32ev_black", 32'(black), 32'h1);
        check("fo_32ev_busy", 32'(fade_busy), 32'h0);
        check("fo_32ev_red", 32'(red), 32'h0);
        check("fo_32ev_grn", 32'(grn), 32'h0);

        // Fade back in from dark
        pulse_req();
        check("fi_busy", 32'(fade_busy), 32'h1);
        check("fi_black", 32'(black), 32'h0);
        frames(32);
        check("fi_done_busy", 32'(fade_busy), 32'h0);
        check("fi_done_red", 32'(red), 32'hF);

        // 4. Fade out to lvl 8, then reverse
        pulse_req();
        frames(16);
        check("half_red", 32'(red), 32'h7);
        check("half_grn", 32'(grn), 32'h4);
        pulse_req();
        check("rev_busy", 32'(fade_busy), 32'h1);
        check("rev_red", 32'(red), 32'h7);
        frames(15);
        check("rev_15ev_busy", 32'(fade_busy), 32'h1);
        frames(1);
        check("rev_16ev_busy", 32'(fade_busy), 32'h0);
        check("rev_16ev_black", 32'(black), 32'h0);
        check("rev_16ev_red", 32'(red), 32'hF);
        check("rev_16ev_grn", 32'(grn), 32'h8);

        // 5. fade_req coincident with a frame event: no step that cycle
        vsync_in = 1'b1;
        pulse_req();
        vsync_in = 1'b0;
        tick();
        check("coinc_busy", 32'(fade_busy), 32'h1);
        frames(1);
        check("coinc_1ev_red", 32'(red), 32'hF);
        frames(1);
        check("coinc_2ev_red", 32'(red), 32'hE);

        // Reset mid-fade
        reset = 1'b0;
        tick();
        check("midrst_busy", 32'(fade_busy), 32'h0);
        check("midrst_red", 32'(red), 32'h0);
        reset = 1'b1;
        tick();
        check("postrst_red", 32'(red), 32'hF);
        check("postrst_grn", 32'(grn), 32'h8);
        check("postrst_black", 32'(black), 32'h0);

`ifdef TEST_PATTERN_EN
        // 6. Colour bar 3
        tp_en = 1'b1;
        pix_x = 10'd384;
        tick();
        check("tp_red", 32'(red), 32'h0);
        check("tp_grn", 32'(grn), 32'hF);
        check("tp_blu", 32'(blu), 32'hF);
        tp_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
